// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: enable levels,
// instruction address type and the stall-vector encodings per requesting stage.
package pipeline_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int INST_ADDR_W = 32;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  // bit0=PC ... bit5=WB; a stage freezes itself and everything upstream
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  function automatic logic [5:0] encodeStall(input logic ifReq, input logic idReq,
                                             input logic exReq, input logic memReq);
    logic [5:0] vec;
    vec = STALL_NONE;
    if (memReq)     vec = STALL_MEM;
    else if (exReq) vec = STALL_EX;
    else if (idReq) vec = STALL_ID;
    else if (ifReq) vec = STALL_IF;
    return vec;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of stage stall requests, flush request and the controller's
// stall/flush outputs; the controller is the slave side.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic       stallreq_if_i;
  logic       stallreq_id_i;
  logic       stallreq_ex_i;
  logic       stallreq_mem_i;
  logic       flush_req_i;
  inst_addr_t flush_pc_i;
  logic [5:0] stall_o;
  logic       flush_o;
  inst_addr_t new_pc_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output flush_req_i, flush_pc_i,
    input  stall_o, flush_o, new_pc_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  flush_req_i, flush_pc_i,
    output stall_o, flush_o, new_pc_o
  );

endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Debug watchdog: consecutive-stall counter with a sticky timeout flag,
// plus a saturating count of all stalled cycles.
module pipeline_ctrl_stall_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stalled_i,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0]      wdCnt_q, wdCnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  // The watchdog counter parks at the limit so it never wraps during a hang
  always_comb begin
    wdCnt_d   = '0;
    timeout_d = timeout_q;
    cycles_d  = cycles_q;
    if (stalled_i) begin
      wdCnt_d = (wdCnt_q == WD_LIMIT) ? wdCnt_q : wdCnt_q + 16'd1;
      if (wdCnt_q == WD_LIMIT) timeout_d = 1'b1;
      if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdCnt_q   <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      wdCnt_q   <= wdCnt_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign stall_timeout_o = timeout_q;
  assign stall_cycles_o  = cycles_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 6-stage pipeline: merges stage stall
// requests and sequences flushes behind a busy memory stage.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_ctrl_if.slave   ctrl,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH_WAIT, FLUSH} state_t;

  state_t     state_q, state_d;
  inst_addr_t pcPend_q, pcPend_d;
  inst_addr_t newPc_q, newPc_d;
  logic [5:0] stallVec;
  logic [5:0] reqVec;
  logic       anyReq;
  logic       flush;

  assign reqVec = encodeStall(ctrl.stallreq_if_i, ctrl.stallreq_id_i,
                              ctrl.stallreq_ex_i, ctrl.stallreq_mem_i);
  assign anyReq = (reqVec != STALL_NONE);

  // new_pc is loaded on entry to FLUSH; a same-cycle request carries the newest PC
  always_comb begin
    state_d  = state_q;
    pcPend_d = pcPend_q;
    newPc_d  = newPc_q;
    stallVec = STALL_NONE;
    flush    = DISABLE;
    case (state_q)
      RUN, STALL: begin
        stallVec = reqVec;
        if (ctrl.flush_req_i) begin
          pcPend_d = ctrl.flush_pc_i;
          if (ctrl.stallreq_mem_i) begin
            state_d = FLUSH_WAIT;
          end else begin
            state_d = FLUSH;
            newPc_d = ctrl.flush_pc_i;
          end
        end else begin
          state_d = anyReq ? STALL : RUN;
        end
      end
      FLUSH_WAIT: begin
        stallVec = STALL_MEM;
        if (ctrl.flush_req_i) pcPend_d = ctrl.flush_pc_i;
        if (!ctrl.stallreq_mem_i) begin
          state_d = FLUSH;
          newPc_d = ctrl.flush_req_i ? ctrl.flush_pc_i : pcPend_q;
        end
      end
      FLUSH: begin
        flush    = ENABLE;
        stallVec = ctrl.stallreq_mem_i ? STALL_MEM : STALL_NONE;
        if (ctrl.flush_req_i) pcPend_d = ctrl.flush_pc_i;
        state_d = anyReq ? STALL : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pcPend_q <= '0;
      newPc_q  <= '0;
    end else begin
      state_q  <= state_d;
      pcPend_q <= pcPend_d;
      newPc_q  <= newPc_d;
    end
  end

  // Stall vector is forced idle while reset is asserted
  assign ctrl.stall_o  = rst_n ? stallVec : STALL_NONE;
  assign ctrl.flush_o  = flush;
  assign ctrl.new_pc_o = newPc_q;

  pipeline_ctrl_stall_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) uWatchdog (
    .clk            (clk),
    .rst_n          (rst_n),
    .stalled_i      (ctrl.stall_o != STALL_NONE),
    .stall_timeout_o(stall_timeout_o),
    .stall_cycles_o (stall_cycles_o)
  );

endmodule
